// File: rtl/apb_seq_pkg.sv
// Shared opcodes, FSM states and command-word sizing for the APB sequencing master.
package apb_seq_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'd0,
    OP_RD   = 2'd1,
    OP_POLL = 2'd2,
    OP_WAIT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_e;

  // Packed command word: {op, addr, data, mask}.
  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 2 + aw + 2 * dw;
  endfunction

endpackage

// File: rtl/apb_seq_fifo.sv
// Synchronous command FIFO with registered occupancy; head word is visible without a pop.
module apb_seq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_seq_master.sv
// APB master executing queued WR/RD/POLL/WAIT commands with a response channel.
module apb_seq_master
  import apb_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned POLL_MAX = 255,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic                   i_pclk,
  input  logic                   i_prst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  input  logic [DATA_W-1:0]      i_cmd_data,
  input  logic [DATA_W-1:0]      i_cmd_mask,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_W-1:0]      o_rsp_data,
  output logic                   o_rsp_err,
  output logic [ADDR_W-1:0]      o_paddr,
  output logic [DATA_W-1:0]      o_pwdata,
  output logic                   o_pwrite,
  output logic                   o_psel,
  output logic                   o_penable,
  input  logic [DATA_W-1:0]      i_prdata,
  input  logic                   i_pready,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int unsigned PW    = $clog2(POLL_MAX + 1);
  localparam int unsigned CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  logic [CMD_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              push_en;
  logic              pop;
  logic [LW-1:0]     lvl_n;
  logic [1:0]        head_op_raw;
  op_e               head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] head_mask;

  state_e            state_q, state_n;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mask_q;
  logic [PW-1:0]     attempt_q;
  logic [WAIT_W-1:0] wait_q;

  logic              done;
  logic              to_resp;
  logic              err_n;
  logic              retry;
  logic              match;

  assign o_cmd_ready = !full;
  assign push_en     = i_cmd_valid && o_cmd_ready;
  assign {head_op_raw, head_addr, head_data, head_mask} = head;
  assign head_op     = op_e'(head_op_raw);
  assign match       = ((i_prdata & mask_q) == (data_q & mask_q));

  apb_seq_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_pclk),
    .rst_n (i_prst_n),
    .push  (push_en),
    .wdata ({i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask}),
    .pop   (pop),
    .rdata (head),
    .level (o_level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    case ({push_en, pop})
      2'b10:   lvl_n = o_level + 1'b1;
      2'b01:   lvl_n = o_level - 1'b1;
      default: lvl_n = o_level;
    endcase
  end

  // 'done' marks a point where the next command may be dispatched without an IDLE cycle.
  always_comb begin
    state_n = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    to_resp = 1'b0;
    err_n   = 1'b0;
    retry   = 1'b0;
    case (state_q)
      S_IDLE:  done = 1'b1;
      S_SETUP: state_n = S_ACCESS;
      S_ACCESS: begin
        if (i_pready) begin
          case (op_q)
            OP_WR: done = 1'b1;
            OP_POLL: begin
              if (match) begin
                to_resp = 1'b1;
              end else if (attempt_q == POLL_LAST) begin
                to_resp = 1'b1;
                err_n   = 1'b1;
              end else begin
                retry   = 1'b1;
                state_n = S_SETUP;
              end
            end
            default: to_resp = 1'b1;
          endcase
        end
      end
      S_WAIT:  if (wait_q == '0) done = 1'b1;
      S_RESP:  if (i_rsp_ready) done = 1'b1;
      default: state_n = S_IDLE;
    endcase
    if (to_resp) state_n = S_RESP;
    if (done) begin
      if (!empty) begin
        pop     = 1'b1;
        state_n = (head_op == OP_WAIT) ? S_WAIT : S_SETUP;
      end else begin
        state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      data_q      <= '0;
      mask_q      <= '0;
      attempt_q   <= '0;
      wait_q      <= '0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
      o_pwrite    <= 1'b0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_n;
      o_psel      <= (state_n == S_SETUP) || (state_n == S_ACCESS);
      o_penable   <= (state_n == S_ACCESS);
      o_rsp_valid <= (state_n == S_RESP);
      o_busy      <= (state_n != S_IDLE) || (lvl_n != '0);
      if (pop) begin
        op_q      <= head_op;
        data_q    <= head_data;
        mask_q    <= head_mask;
        attempt_q <= PW'(1);
        wait_q    <= head_data[WAIT_W-1:0];
        if (head_op != OP_WAIT) begin
          o_paddr  <= head_addr;
          o_pwrite <= (head_op == OP_WR);
          o_pwdata <= head_data;
        end
      end else if (state_q == S_WAIT && wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end
      if (retry) attempt_q <= attempt_q + 1'b1;
      if (to_resp) begin
        o_rsp_data <= i_prdata;
        o_rsp_err  <= err_n;
      end
    end
  end

endmodule
